// File: rtl/dcp_pkg.sv
// Shared constants for the pipelined 48-bit add/subtract datapath.
// Slice width, full word width and the signed saturation limits.
package dcp_pkg;

   localparam int W_SLICE = 24;
   localparam int W_DATA  = 2 * W_SLICE;

   localparam logic [W_DATA-1:0] SAT_POS48 = 48'h7FFF_FFFF_FFFF;
   localparam logic [W_DATA-1:0] SAT_NEG48 = 48'h8000_0000_0000;

   // Clamp value chosen by the sign of the operand that overflowed.
   function automatic logic [W_DATA-1:0] sat_value(input logic neg);
      return neg ? SAT_NEG48 : SAT_POS48;
   endfunction

endpackage

// File: rtl/addsub48p_add24c.sv
// Registered 24-bit adder slice with carry in/out, clock enable and
// synchronous clear; sum and carry are captured together.
module add24c
   import dcp_pkg::*;
(
   input  logic               clk,
   input  logic               sclr,
   input  logic               ce,
   input  logic [W_SLICE-1:0] a,
   input  logic [W_SLICE-1:0] b,
   input  logic               ci,
   output logic [W_SLICE-1:0] s,
   output logic               co
);

   logic [W_SLICE:0] sum;

   assign sum = {1'b0, a} + {1'b0, b} + {{W_SLICE{1'b0}}, ci};

   always_ff @(posedge clk) begin
      if (sclr) begin
         s  <= '0;
         co <= 1'b0;
      end else if (ce) begin
         s  <= sum[W_SLICE-1:0];
         co <= sum[W_SLICE];
      end
   end

endmodule

// File: rtl/addsub48p.sv
// Two-stage 48-bit add/subtract: low slice in stage 1, high slice in stage 2
// with the slice carry chained between them; signed overflow and optional clamp.
module addsub48p
   import dcp_pkg::*;
#(
   parameter bit SAT = 1'b0
)
(
   input  logic              CLK,
   input  logic              SCLR,
   input  logic              CE,
   input  logic              VI,
   input  logic              SUB,
   input  logic [W_DATA-1:0] A,
   input  logic [W_DATA-1:0] B,
   input  logic              CI,
   output logic [W_DATA-1:0] Q,
   output logic              CO,
   output logic              OVF,
   output logic              VO
);

   // Valid handshake: there is no ready. VO is VI delayed by exactly two
   // CE-qualified edges; the datapath is never gated, so qualify Q with VO.

   logic [W_DATA-1:0]  b_x;
   logic               c_x;
   logic [W_SLICE-1:0] lo;
   logic               c24;
   logic [W_SLICE-1:0] a_h;
   logic [W_SLICE-1:0] b_h;
   logic               sub_1;
   logic               vi_1;
   logic [W_SLICE-1:0] hi;
   logic               c48;
   logic [W_SLICE-1:0] lo_2;
   logic               a_sign_2;
   logic               b_sign_2;
   logic               sub_2;
   logic               vi_2;
   logic               ovf;

   // Subtraction as A + ~B + ~CI, so CI acts as a borrow.
   assign b_x = SUB ? ~B  : B;
   assign c_x = SUB ? ~CI : CI;

   add24c u_lo (
      .clk  (CLK),
      .sclr (SCLR),
      .ce   (CE),
      .a    (A[W_SLICE-1:0]),
      .b    (b_x[W_SLICE-1:0]),
      .ci   (c_x),
      .s    (lo),
      .co   (c24)
   );

   always_ff @(posedge CLK) begin
      if (SCLR) begin
         a_h   <= '0;
         b_h   <= '0;
         sub_1 <= 1'b0;
         vi_1  <= 1'b0;
      end else if (CE) begin
         a_h   <= A[W_DATA-1:W_SLICE];
         b_h   <= b_x[W_DATA-1:W_SLICE];
         sub_1 <= SUB;
         vi_1  <= VI;
      end
   end

   add24c u_hi (
      .clk  (CLK),
      .sclr (SCLR),
      .ce   (CE),
      .a    (a_h),
      .b    (b_h),
      .ci   (c24),
      .s    (hi),
      .co   (c48)
   );

   // Operand signs ride alongside the high slice so overflow sees stage-2 data.
   always_ff @(posedge CLK) begin
      if (SCLR) begin
         lo_2     <= '0;
         a_sign_2 <= 1'b0;
         b_sign_2 <= 1'b0;
         sub_2    <= 1'b0;
         vi_2     <= 1'b0;
      end else if (CE) begin
         lo_2     <= lo;
         a_sign_2 <= a_h[W_SLICE-1];
         b_sign_2 <= b_h[W_SLICE-1];
         sub_2    <= sub_1;
         vi_2     <= vi_1;
      end
   end

   assign ovf = (a_sign_2 == b_sign_2) && (hi[W_SLICE-1] != a_sign_2);

   assign Q   = (SAT && ovf) ? sat_value(a_sign_2) : {hi, lo_2};
   assign CO  = c48 ^ sub_2;
   assign OVF = ovf;
   assign VO  = vi_2;

endmodule
